// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous instruction memory with NOP self-init, stall/flush and prog port
// Registered fetch output; the memory is NOP-filled after every reset before fetch is accepted.
module instr_mem_sync #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                PC_W      = 32,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'hFC000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_addr,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              prog_ack,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LSB   = (BYTE_ADDR != 0) ? 2 : 0;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              ack_q, ack_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] idx;
  logic              pc_fault;

  // Index is a plain bit-select; any set bit above it is a fault, never a wrap.
  assign idx      = ADDR_W'(pc_addr >> LSB);
  assign pc_fault = (|(pc_addr >> (LSB + ADDR_W))) ||
                    ((BYTE_ADDR != 0) && (pc_addr[1:0] != 2'b00));

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    ack_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = prog_addr;
    mem_wdata  = prog_data;
    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q[ADDR_W-1:0];
        mem_wdata  = NOP_WORD;
        init_cnt_d = init_cnt_q + (ADDR_W + 1)'(1);
        if (init_cnt_q == LAST_CNT) state_d = S_RUN;
      end
      S_RUN: begin
        mem_we = prog_we;
        ack_d  = prog_we;
        if (flush) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else if (stall) begin
          instr_d = instr_q;
        end else if (fetch_en) begin
          valid_d = 1'b1;
          fault_d = pc_fault;
          // Combinational read before the same-edge write gives read-before-write.
          instr_d = pc_fault ? NOP_WORD : mem[idx];
        end else begin
          valid_d = 1'b0;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      ack_q      <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign addr_fault  = fault_q;
  assign prog_ack    = ack_q;
  assign ready       = (state_q == S_RUN);

endmodule
